// File: rtl/f7_frame_accum.sv
// f7_frame_accum: decodes 7-bit minifloat codes and sums them per frame.
// Build option F7_ACCUM_SAT_EN: saturate the accumulator instead of wrapping.
module f7_frame_accum #(
  parameter  int ACC_W     = 20,
  parameter  int FRAME_LEN = 16,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [10:0] dval;
    logic        dv;
    logic        dend;
  } stg_t;

  state_t           state;
  state_t           state_nxt;
  stg_t             stg;
  logic [CNT_W-1:0] beat_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf;
  logic [ACC_W:0]   sum;
  logic [10:0]      dec;
  logic             accept;
  logic             dend_c;
  logic             flush_done;
  logic             hs;

  assign accept     = in_valid & in_ready;
  assign dend_c     = in_last | (beat_cnt == CNT_W'(FRAME_LEN - 1));
  assign flush_done = ~(stg.dv & stg.dend);
  assign hs         = out_valid & out_ready;

  always_comb begin
    dec = '0;
    unique case (1'b1)
      (in_code[6:4] == 3'd0):
        dec = {7'd0, in_code[3:0]};
      default:
        dec = {6'd0, 1'b1, in_code[3:0]} << (in_code[6:4] - 3'd1);
    endcase
  end

  // Carry out of the wide add marks overflow for this frame.
  always_comb begin
    sum = {1'b0, acc} + {{(ACC_W - 10){1'b0}}, stg.dval};
`ifdef F7_ACCUM_SAT_EN
    acc_nxt = (sum[ACC_W] | ovf) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    acc_nxt = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACC:     if (accept && dend_c) state_nxt = FLUSH;
      FLUSH:   if (flush_done)       state_nxt = HOLD;
      HOLD:    if (out_ready)        state_nxt = ACC;
      default:                       state_nxt = ACC;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg       <= '0;
      beat_cnt  <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      stg <= '0;
      if (accept) begin
        stg      <= '{dval: dec, dv: 1'b1, dend: dend_c};
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (stg.dv) begin
        acc <= acc_nxt;
        ovf <= ovf | sum[ACC_W];
      end
      // Result is latched once the closing beat has reached acc.
      if (state == FLUSH && flush_done) begin
        out_sum   <= acc;
        out_count <= beat_cnt;
        out_ovf   <= ovf;
      end
      if (hs) begin
        acc      <= '0;
        ovf      <= 1'b0;
        beat_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_f7_frame_accum.sv
// tb_f7_frame_accum: vector table, corner sequences and random frames
// checked against an arithmetic frame-sum model.
module tb_f7_frame_accum;

  localparam int ACC_W = 12;
  localparam int FL    = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [6:0]    in_code = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [ACC_W-1:0] out_sum;
  logic [CW-1:0] out_count;
  logic          out_ovf;

  int total = 0;
  int bad = 0;

  f7_frame_accum #(.ACC_W(ACC_W), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] code [4];
    int n;
    int last_at;
    int sum_w;
    int sum_s;
    int cnt;
    int ovf;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int dec(input logic [6:0] c);
    int e, m;
    e = int'(c[6:4]);
    m = int'(c[3:0]);
    if (e == 0) return m;
    return (16 + m) * (1 << (e - 1));
  endfunction

  function automatic int model(input int raw);
`ifdef F7_ACCUM_SAT_EN
    return (raw >= (1 << ACC_W)) ? (1 << ACC_W) - 1 : raw;
`else
    return raw % (1 << ACC_W);
`endif
  endfunction

  function automatic int pick(input int w, input int s);
`ifdef F7_ACCUM_SAT_EN
    return s + 0 * w;
`else
    return w + 0 * s;
`endif
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [6:0] c, input logic l, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_code  = c;
    in_last  = l;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect(input int pct, output int s, output int c,
                         output int o);
    int n;
    bit got;
    n = 0;
    got = 0;
    s = -1; c = -1; o = -1;
    while (!got && n < 100) begin
      @(negedge clk);
      out_ready = ($urandom_range(99) < pct);
      if (out_valid && out_ready) begin
        s = int'(out_sum);
        c = int'(out_count);
        o = int'(out_ovf);
        got = 1;
      end
      n++;
    end
    if (!got) chk("collect_timeout", 0, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic idle_check(input string nm);
    int seen;
    seen = 0;
    @(negedge clk);
    chk({nm, "_ready"}, int'(in_ready), 1);
    repeat (3) begin
      @(negedge clk);
      seen += int'(out_valid);
    end
    chk({nm, "_no_empty"}, seen, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int s, c, o, raw, n, la, nb;
    logic [6:0] cc [4];

    tbl[0] = '{code: '{7'h05, 7'h10, 7'h7F, 7'h23}, n: 4, last_at: 0,
               sum_w: 2043, sum_s: 2043, cnt: 4, ovf: 0};
    tbl[1] = '{code: '{7'h01, 7'h02, 7'h00, 7'h00}, n: 2, last_at: 2,
               sum_w: 3, sum_s: 3, cnt: 2, ovf: 0};
    tbl[2] = '{code: '{7'h7F, 7'h7F, 7'h7F, 7'h7F}, n: 4, last_at: 0,
               sum_w: 3840, sum_s: 4095, cnt: 4, ovf: 1};
    tbl[3] = '{code: '{7'h00, 7'h00, 7'h00, 7'h00}, n: 1, last_at: 1,
               sum_w: 0, sum_s: 0, cnt: 1, ovf: 0};
    tbl[4] = '{code: '{7'h7F, 7'h7F, 7'h7F, 7'h01}, n: 4, last_at: 4,
               sum_w: 1857, sum_s: 4095, cnt: 4, ovf: 1};
    tbl[5] = '{code: '{7'h7F, 7'h7F, 7'h10, 7'h00}, n: 3, last_at: 3,
               sum_w: 3984, sum_s: 3984, cnt: 3, ovf: 0};
    tbl[6] = '{code: '{7'h08, 7'h18, 7'h2F, 7'h00}, n: 3, last_at: 3,
               sum_w: 94, sum_s: 94, cnt: 3, ovf: 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < tbl[i].n; b++)
        send(tbl[i].code[b], logic'(b + 1 == tbl[i].last_at), 0);
      collect(100, s, c, o);
      chk($sformatf("vec%0d_sum", i), s, pick(tbl[i].sum_w, tbl[i].sum_s));
      chk($sformatf("vec%0d_cnt", i), c, tbl[i].cnt);
      chk($sformatf("vec%0d_ovf", i), o, tbl[i].ovf);
      idle_check($sformatf("vec%0d", i));
    end

    // Latency and hold with out_ready low
    send(7'h05, 1'b0, 0);
    send(7'h10, 1'b0, 0);
    send(7'h7F, 1'b0, 0);
    send(7'h23, 1'b0, 0);
    @(negedge clk);
    chk("lat_n0_valid", int'(out_valid), 0);
    chk("lat_n0_ready", int'(in_ready), 0);
    @(negedge clk);
    chk("lat_n1_valid", int'(out_valid), 0);
    chk("lat_n1_ready", int'(in_ready), 0);
    @(negedge clk);
    chk("lat_n2_valid", int'(out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("hold%0d_valid", k), int'(out_valid), 1);
      chk($sformatf("hold%0d_sum", k), int'(out_sum), 2043);
      chk($sformatf("hold%0d_cnt", k), int'(out_count), 4);
      chk($sformatf("hold%0d_ready", k), int'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_ready", int'(in_ready), 1);
    chk("post_hs_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    send(7'h01, 1'b1, 0);
    collect(100, s, c, o);
    chk("fresh_sum", s, 1);
    chk("fresh_cnt", c, 1);

    // Reset mid-frame
    send(7'h05, 1'b0, 0);
    send(7'h10, 1'b0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_sum", int'(out_sum), 0);
    chk("mid_rst_cnt", int'(out_count), 0);
    chk("mid_rst_ovf", int'(out_ovf), 0);
    chk("mid_rst_ready", int'(in_ready), 1);
    for (int b = 0; b < 4; b++) send(tbl[0].code[b], 1'b0, 0);
    collect(100, s, c, o);
    chk("replay_sum", s, 2043);
    chk("replay_cnt", c, 4);

    // Gapped input, random out_ready
    for (int b = 0; b < 4; b++) send(tbl[0].code[b], 1'b0, 1);
    collect(50, s, c, o);
    chk("gap_sum", s, 2043);
    chk("gap_cnt", c, 4);
    chk("gap_ovf", o, 0);

    // Random frames
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, FL);
      la = (n < FL) ? n : ($urandom_range(1) ? FL : 0);
      nb = (n < FL) ? n : FL;
      raw = 0;
      for (int b = 0; b < nb; b++) begin
        cc[b] = 7'($urandom);
        raw += dec(cc[b]);
        send(cc[b], logic'(b + 1 == la), $urandom_range(0, 2));
      end
      collect(50, s, c, o);
      chk($sformatf("rnd%0d_sum", f), s, model(raw));
      chk($sformatf("rnd%0d_cnt", f), c, nb);
      chk($sformatf("rnd%0d_ovf", f), o, int'(raw >= (1 << ACC_W)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
